uart_rx_fifo: RTL

Buffered UART receiver that sits directly upstream of the UART-to-memory loader. Deserialises 8N1 frames from the board RX pin, checks the stop bit, and queues received bytes in a first-word-fall-through FIFO. The loader drains it one byte per `rd_en` pulse, so bytes are not lost while it is busy writing a word to instruction memory. Sticky error flags report framing errors and FIFO overruns to LEDs or debug logic.

---
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky error flags.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each bit centre (+1 cycle latency).
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_serial,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  frame_err,
    output logic                  overrun_err,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_LAST = HALF;
`else
    localparam int START_LAST = HALF - 1;
`endif
    localparam logic [CNT_W-1:0]      START_END = CNT_W'(START_LAST);
    localparam logic [CNT_W-1:0]      BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;

    // Synchroniser resets low so WAIT_IDLE only leaves on a genuinely idle line.
    logic [1:0] sync_q;
    logic       rxs;
    logic       sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], rx_serial};
    end
    assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b00;
        else        hist_q <= {hist_q[0], rxs};
    end
    assign sample = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rxs;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             push;
    logic             frame_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == START_END) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
                    if (sample) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full, pop, wr_ok, ovr_set;

    assign full    = (count_q == FULL_CNT);
    assign pop     = rd_en & (count_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign wr_ok   = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop)      count_d = count_q + 1'b1;
        else if (!wr_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    logic frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;

    always_comb begin
        frame_err_d   = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        overrun_err_d = ovr_set   ? 1'b1 : (err_clr ? 1'b0 : overrun_err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rd_valid    = (count_q != '0);
    assign rd_data     = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count  = count_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule
